// File: rtl/muldiv_seq_if.sv
// Handshake and data bundle between the pipeline and the sequential multiply/divide unit.
// The pipeline drives through master; the unit implements slave.
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        flush;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op, in0, in1, flush, mthi, mtlo, wdata,
    input  busy, done, dz, hi_out, lo_out
  );

  modport slave (
    input  start, op, in0, in1, flush, mthi, mtlo, wdata,
    output busy, done, dz, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit with architectural HI/LO registers.
// Each operation takes one bit per cycle on unsigned magnitudes, with signs fixed up at the end.
module muldiv_seq (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] in0_q, in1_q;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [31:0] hi_q, lo_q;
  logic        done_q, dz_q;

  logic        launch;
  logic        start_signed;
  logic [31:0] mag0, mag1;
  logic        is_div, is_signed;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_next, div_next;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic [31:0] res_hi, res_lo;

  assign launch       = (state == IDLE) && bus.start && !bus.flush;
  assign start_signed = ~bus.op[0];
  assign mag0         = (start_signed && bus.in0[31]) ? -bus.in0 : bus.in0;
  assign mag1         = (start_signed && bus.in1[31]) ? -bus.in1 : bus.in1;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

  // Divide: acc = {partial remainder, dividend bits becoming quotient bits}.
  assign div_trial = acc[63:31] - {1'b0, opnd};
  assign div_next  = div_trial[32] ? {acc[62:0], 1'b0}
                                   : {div_trial[31:0], acc[30:0], 1'b1};

  assign prod = (is_signed && (in0_q[31] ^ in1_q[31])) ? -acc : acc;
  assign quo  = (is_signed && (in0_q[31] ^ in1_q[31])) ? -acc[31:0] : acc[31:0];
  assign rem  = (is_signed && in0_q[31]) ? -acc[63:32] : acc[63:32];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      if (in1_q == 32'd0) begin
        res_hi = in0_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (bus.flush) state_nxt = IDLE;
               else if (cnt == 6'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      in0_q  <= '0;
      in1_q  <= '0;
      opnd   <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.wdata;
          if (bus.mtlo) lo_q <= bus.wdata;
          if (launch) begin
            op_q  <= bus.op;
            in0_q <= bus.in0;
            in1_q <= bus.in1;
            cnt   <= '0;
            opnd  <= bus.op[1] ? mag1 : mag0;
            acc   <= {32'd0, bus.op[1] ? mag0 : mag1};
          end
        end
        RUN: begin
          if (!bus.flush) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 6'd1;
          end
        end
        FIX: begin
          // Flush wins over the result write: HI/LO/dz stay as they were.
          if (!bus.flush) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            dz_q   <= is_div && (in1_q == 32'd0);
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.dz     = dz_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, arithmetic corner cases, flush and mid-operation reset.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called in cycle 0 (start-sampling cycle); returns in cycle 1.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.in0   = a;
    bus.in1   = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called in cycle 1; checks cycles 1..33 and returns in cycle 34 after checking the result.
  task automatic finish_op(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dz);
    logic        ok_busy, ok_done, ok_hold;
    logic [31:0] h0, l0;
    ok_busy = 1'b1;
    ok_done = 1'b1;
    ok_hold = 1'b1;
    h0 = bus.hi_out;
    l0 = bus.lo_out;
    for (int c = 1; c <= 33; c++) begin
      if (bus.busy !== 1'b1) ok_busy = 1'b0;
      if (bus.done !== 1'b0) ok_done = 1'b0;
      if (bus.hi_out !== h0 || bus.lo_out !== l0) ok_hold = 1'b0;
      @(negedge clk);
    end
    chk({tag, " busy_1_33"}, 32'(ok_busy), 32'd1);
    chk({tag, " no_early_done"}, 32'(ok_done), 32'd1);
    chk({tag, " hilo_hold"}, 32'(ok_hold), 32'd1);
    chk({tag, " busy_34"}, 32'(bus.busy), 32'd0);
    chk({tag, " done_34"}, 32'(bus.done), 32'd1);
    chk({tag, " hi"}, bus.hi_out, exp_hi);
    chk({tag, " lo"}, bus.lo_out, exp_lo);
    chk({tag, " dz"}, 32'(bus.dz), 32'(exp_dz));
  endtask

  task automatic idle_step(input string tag);
    @(negedge clk);
    chk({tag, " done_drop"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic ok_busy, ok_done;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.in0   = '0;
    bus.in1   = '0;
    bus.flush = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst dz", 32'(bus.dz), 32'd0);
    chk("rst hi", bus.hi_out, 32'd0);
    chk("rst lo", bus.lo_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Direct HI/LO writes in IDLE
    bus.mthi = 1'b1; bus.wdata = 32'h1111_2222;
    @(negedge clk);
    bus.mthi = 1'b0;
    chk("mthi", bus.hi_out, 32'h1111_2222);
    bus.mtlo = 1'b1; bus.wdata = 32'h3333_4444;
    @(negedge clk);
    bus.mtlo = 1'b0;
    chk("mtlo", bus.lo_out, 32'h3333_4444);
    chk("mtlo hi_keep", bus.hi_out, 32'h1111_2222);

    launch(2'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    finish_op("mult -3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    idle_step("mult -3x7");

    // Back-to-back: second start issued in cycle 34 of the first
    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    launch(2'd0, 32'h1234_5678, 32'h0000_0010);
    finish_op("mult b2b", 32'h0000_0001, 32'h2345_6780, 1'b0);
    idle_step("mult b2b");

    launch(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    finish_op("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    idle_step("div -7/2");
    launch(2'd3, 32'h0000_0007, 32'h0000_0002);
    finish_op("divu 7/2", 32'h0000_0001, 32'h0000_0003, 1'b0);
    idle_step("divu 7/2");
    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div min/-1", 32'h0000_0000, 32'h8000_0000, 1'b0);
    idle_step("div min/-1");
    launch(2'd3, 32'h0000_0005, 32'h0000_0000);
    finish_op("divu 5/0", 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    idle_step("divu 5/0");
    launch(2'd2, 32'h0000_0007, 32'hFFFF_FFFE);
    finish_op("div 7/-2", 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    idle_step("div 7/-2");
    launch(2'd2, 32'hFFFF_FFF8, 32'h0000_0000);
    finish_op("div -8/0", 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
    idle_step("div -8/0");

    // start coinciding with mtlo: write lands, result overwrites later
    bus.op = 2'd1; bus.in0 = 32'd3; bus.in1 = 32'd5;
    bus.start = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.mtlo = 1'b0;
    chk("start+mtlo lo", bus.lo_out, 32'hDEAD_BEEF);
    finish_op("multu 3x5", 32'h0000_0000, 32'h0000_000F, 1'b0);
    idle_step("multu 3x5");

    // Flush: start/mthi while busy are ignored, flush+start in IDLE launches nothing
    bus.mthi = 1'b1; bus.wdata = 32'hCAFE_0001;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'hCAFE_0002;
    @(negedge clk);
    bus.mtlo = 1'b0;
    launch(2'd0, 32'd3, 32'd3);
    ok_busy = 1'b1;
    ok_done = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy !== (c <= 10)) ok_busy = 1'b0;
      if (bus.done !== 1'b0) ok_done = 1'b0;
      bus.start = (c >= 5 && c <= 12);
      bus.mthi  = (c >= 5 && c <= 10);
      bus.wdata = 32'h9999_9999;
      bus.flush = (c >= 10 && c <= 12);
      @(negedge clk);
    end
    bus.start = 1'b0; bus.mthi = 1'b0; bus.flush = 1'b0;
    chk("flush busy_profile", 32'(ok_busy), 32'd1);
    chk("flush no_done", 32'(ok_done), 32'd1);
    chk("flush hi", bus.hi_out, 32'hCAFE_0001);
    chk("flush lo", bus.lo_out, 32'hCAFE_0002);
    chk("flush dz", 32'(bus.dz), 32'd0);

    // Reset mid-divide
    launch(2'd2, 32'd100, 32'd7);
    for (int c = 1; c < 20; c++) @(negedge clk);
    chk("pre_rst busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst busy", 32'(bus.busy), 32'd0);
    chk("async_rst done", 32'(bus.done), 32'd0);
    chk("async_rst dz", 32'(bus.dz), 32'd0);
    chk("async_rst hi", bus.hi_out, 32'd0);
    chk("async_rst lo", bus.lo_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok_busy = 1'b1;
    ok_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) ok_busy = 1'b0;
      if (bus.done !== 1'b0) ok_done = 1'b0;
    end
    chk("post_rst idle", 32'(ok_busy), 32'd1);
    chk("post_rst no_done", 32'(ok_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  launch request, sampled in IDLE only.
REQ-005 op  in  2  operation: 0 MULT (signed), 1 MULTU, 2 DIV (signed), 3 DIVU.
REQ-006 in0  in  32  rs operand (multiplicand / dividend).
REQ-007 in1  in  32  rt operand (multiplier / divisor).
REQ-008 flush  in  1  abort any in-flight operation.
REQ-009 mthi  in  1  write wdata to HI.
REQ-010 mtlo  in  1  write wdata to LO.
REQ-011 wdata  in  32  data for mthi/mtlo.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE; pipeline stalls MFHI/MFLO/MULT/DIV on it.
REQ-013 done  out  1  one-cycle pulse when HI/LO take a new result.
REQ-014 dz  out  1  last completed divide had divisor zero.
REQ-015 hi_out  out  32  architectural HI register.
REQ-016 lo_out  out  32  architectural LO register.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and FIX; busy = (state != IDLE).
REQ-018 In IDLE, start=1 with flush=0 SHALL latch op, in0 and in1, compute operand magnitudes for signed ops, clear the 6-bit step counter, and enter RUN.
REQ-019 RUN SHALL process one operand bit per cycle (shift-add for multiply, restoring shift-subtract for divide) on internal registers, and SHALL move to FIX after exactly 32 RUN edges.
REQ-020 FIX SHALL apply sign correction, write HI/LO, set done=1 for one cycle, and return to IDLE on the same edge.
REQ-021 Latency, with the start-sampling cycle numbered 0: busy SHALL be high in cycles 1..33, done and the new HI/LO SHALL appear in cycle 34, and busy SHALL be 0 in cycle 34.
REQ-022 Multiply SHALL produce the full 64-bit product, HI=[63:32] and LO=[31:0]; MULT SHALL treat operands as two's complement and MULTU as unsigned.
REQ-023 Divide SHALL set LO=quotient and HI=remainder; DIV SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0, with no exception.
REQ-025 Divisor 0 (DIV or DIVU) SHALL give LO=0xFFFFFFFF and HI=in0 as latched, and SHALL set dz=1.
REQ-026 Any completed operation with a non-zero divisor, and any multiply, SHALL clear dz when it completes.
REQ-027 hi_out and lo_out SHALL hold their values during RUN and FIX and change only at the FIX edge, on mthi/mtlo, or on reset.
REQ-028 mthi/mtlo in IDLE SHALL write wdata on the next edge; while busy they SHALL be ignored.
REQ-029 If start and mthi/mtlo coincide in IDLE, the write SHALL occur and the operation SHALL start; the operation's result later overwrites both HI and LO.
REQ-030 start while busy SHALL be ignored, and no queuing SHALL occur.
REQ-031 start in the same cycle as done SHALL be accepted, because the FSM is already in IDLE.
REQ-032 flush in RUN or FIX SHALL return the FSM to IDLE on the next edge, with no done pulse and HI/LO/dz unchanged; flush SHALL take priority over the FIX write.
REQ-033 flush together with start in IDLE SHALL ignore start.

Reset
REQ-034 rst_n=0 SHALL immediately and asynchronously force state=IDLE, busy=0, done=0, dz=0, hi_out=0, lo_out=0 and the counter to 0.
REQ-035 Assertion of rst_n mid-operation SHALL discard the operation, with no done pulse after release.
REQ-036 Reset SHALL take precedence over every input.

Verification
REQ-037 MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high in cycles 1..33 exactly; done high only in cycle 34.
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; a back-to-back start in cycle 34 is accepted and busy rises in cycle 35.
REQ-039 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU 7/2 -> LO=3, HI=1, dz=0.
REQ-040 DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; then DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, dz=1.
REQ-041 Start MULT, assert flush in cycle 10 plus start and mthi in cycles 5..12 -> busy=0 from cycle 11, no done, HI/LO keep their pre-start values, no second operation is launched.
REQ-042 Start DIV, drive rst_n low in cycle 20 -> all outputs 0 before the next clock edge; after release, no done appears and the FSM stays in IDLE.
